amo_sequencer: RTL and testbench

- MEM-stage controller that executes RV32A atomics (LR.W, SC.W, AMO*.W) as a sequenced read-modify-write on the data-memory port.
- Sits after the EXE/MEM pipeline register and consumes its atomic-related fields: is_atomic, atomic_op, ALUout as the address, and opB as the operand.
- Stalls the pipeline while busy, holds the LR/SC reservation, and returns the value to be written back to rd.

---
 rtl/amo_sequencer.sv | 145 ++++++++++++++
 tb/tb_amo_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/amo_sequencer.sv
// RV32A atomic sequencer for the MEM stage: runs LR/SC/AMO as a read-modify-write
// on the data-memory port, stalls the pipe while busy and owns the LR/SC reservation.
module amo_sequencer #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              mem_is_atomic,
  input  logic [3:0]        mem_atomic_op,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_opB,
  input  logic              snoop_wr,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [WORD_W-1:0] dm_wdata,
  output logic [3:0]        dm_be,
  input  logic              dm_gnt,
  input  logic              dm_rvalid,
  input  logic [WORD_W-1:0] dm_rdata,
  output logic              stall,
  output logic              amo_done,
  output logic [WORD_W-1:0] amo_result,
  output logic              amo_misaligned
);
  localparam logic [3:0] OP_LR = 4'd0, OP_SC = 4'd1, OP_SWAP = 4'd2, OP_ADD = 4'd3,
                         OP_XOR = 4'd4, OP_AND = 4'd5, OP_OR = 4'd6, OP_MIN = 4'd7,
                         OP_MAX = 4'd8, OP_MINU = 4'd9, OP_MAXU = 4'd10;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE} state_t;
  state_t state, state_n;

  logic [3:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] opb_q, wdata_q, wdata_n, pend_q, pend_n, amo_val;
  logic              mis_q, mis_n;
  logic              res_valid;
  logic [ADDR_W-3:0] res_addr;
  logic              start, sc_ok;

  assign start = (state == IDLE) && mem_is_atomic;
  assign sc_ok = res_valid && (res_addr == mem_addr[ADDR_W-1:2]);

  // Ties fall through to the old value for all four compare ops.
  always_comb begin
    amo_val = dm_rdata;
    case (op_q)
      OP_SWAP: amo_val = opb_q;
      OP_ADD:  amo_val = dm_rdata + opb_q;
      OP_XOR:  amo_val = dm_rdata ^ opb_q;
      OP_AND:  amo_val = dm_rdata & opb_q;
      OP_OR:   amo_val = dm_rdata | opb_q;
      OP_MIN:  amo_val = ($signed(opb_q) < $signed(dm_rdata)) ? opb_q : dm_rdata;
      OP_MAX:  amo_val = ($signed(opb_q) > $signed(dm_rdata)) ? opb_q : dm_rdata;
      OP_MINU: amo_val = (opb_q < dm_rdata) ? opb_q : dm_rdata;
      OP_MAXU: amo_val = (opb_q > dm_rdata) ? opb_q : dm_rdata;
      default: amo_val = dm_rdata;
    endcase
  end

  always_comb begin
    state_n = state;
    pend_n  = pend_q;
    wdata_n = wdata_q;
    mis_n   = mis_q;
    case (state)
      IDLE: if (mem_is_atomic) begin
        mis_n  = 1'b0;
        pend_n = '0;
        if (mem_addr[1:0] != 2'b00) begin
          mis_n   = 1'b1;
          state_n = DONE;
        end else if (mem_atomic_op == OP_SC) begin
          wdata_n = mem_opB;
          pend_n  = sc_ok ? '0 : WORD_W'(1);
          state_n = sc_ok ? WR_REQ : DONE;
        end else if (mem_atomic_op > OP_MAXU) begin
          state_n = DONE;
        end else begin
          state_n = RD_REQ;
        end
      end
      RD_REQ:  if (dm_gnt) state_n = RD_WAIT;
      RD_WAIT: if (dm_rvalid) begin
        pend_n  = dm_rdata;
        wdata_n = amo_val;
        state_n = (op_q == OP_LR) ? DONE : WR_REQ;
      end
      WR_REQ:  if (dm_gnt) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      opb_q      <= '0;
      wdata_q    <= '0;
      pend_q     <= '0;
      mis_q      <= 1'b0;
      amo_result <= '0;
    end else begin
      state   <= state_n;
      wdata_q <= wdata_n;
      pend_q  <= pend_n;
      mis_q   <= mis_n;
      if (start) begin
        op_q   <= mem_atomic_op;
        addr_q <= mem_addr;
        opb_q  <= mem_opB;
      end
      if (state_n == DONE) amo_result <= pend_n;
    end
  end

  // Later assignments win: an LR set overrides a same-cycle snoop clear.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      res_valid <= 1'b0;
      res_addr  <= '0;
    end else begin
      if (snoop_wr && res_addr == snoop_addr[ADDR_W-1:2]) res_valid <= 1'b0;
      if (start && mem_addr[1:0] == 2'b00 && mem_atomic_op == OP_SC) res_valid <= 1'b0;
      if (state == WR_REQ && dm_gnt && res_addr == addr_q[ADDR_W-1:2]) res_valid <= 1'b0;
      if (state == RD_WAIT && dm_rvalid && op_q == OP_LR) begin
        res_valid <= 1'b1;
        res_addr  <= addr_q[ADDR_W-1:2];
      end
    end
  end

  assign dm_req         = (state == RD_REQ) || (state == WR_REQ);
  assign dm_we          = (state == WR_REQ);
  assign dm_be          = (state == WR_REQ) ? 4'hF : 4'h0;
  assign dm_addr        = dm_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign dm_wdata       = (state == WR_REQ) ? wdata_q : '0;
  assign stall          = start || (state == RD_REQ) || (state == RD_WAIT) || (state == WR_REQ);
  assign amo_done       = (state == DONE);
  assign amo_misaligned = (state == DONE) && mis_q;
endmodule

// File: tb/tb_amo_sequencer.sv
// Scoreboard bench for amo_sequencer: behavioural memory responder, expected
// results/writes queued at issue and checked when amo_done fires.
module tb_amo_sequencer;
  logic        clk = 1'b0, nrst = 1'b0;
  logic        mem_is_atomic = 1'b0, snoop_wr = 1'b0;
  logic [3:0]  mem_atomic_op = '0;
  logic [31:0] mem_addr = '0, mem_opB = '0, snoop_addr = '0;
  logic        dm_req, dm_we, dm_gnt = 1'b0, dm_rvalid = 1'b0;
  logic [31:0] dm_addr, dm_wdata, dm_rdata = '0, amo_result;
  logic [3:0]  dm_be;
  logic        stall, amo_done, amo_misaligned;

  amo_sequencer #(.ADDR_W(32), .WORD_W(32)) dut (
    .clk(clk), .nrst(nrst), .mem_is_atomic(mem_is_atomic), .mem_atomic_op(mem_atomic_op),
    .mem_addr(mem_addr), .mem_opB(mem_opB), .snoop_wr(snoop_wr), .snoop_addr(snoop_addr),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .stall(stall),
    .amo_done(amo_done), .amo_result(amo_result), .amo_misaligned(amo_misaligned));

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  logic [31:0] mem [logic [31:0]];
  int gnt_hold = 0, rv_delay = 1, rd_cnt = 0;
  logic [31:0] rd_addr = '0;

  typedef struct { logic [31:0] res; logic mis; } exp_t;
  exp_t        exp_q[$];
  logic [67:0] exp_wr_q[$];
  logic [67:0] wr_q[$];

  // Memory responder: grant after gnt_hold cycles, read data rv_delay cycles later.
  always @(negedge clk) begin
    dm_gnt = 1'b0;
    dm_rvalid = 1'b0;
    if (!nrst) rd_cnt = 0;
    else begin
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin dm_rvalid = 1'b1; dm_rdata = mem[rd_addr]; end
      end
      if (dm_req) begin
        if (gnt_hold > 0) gnt_hold--;
        else begin
          dm_gnt = 1'b1;
          if (dm_we) begin
            mem[dm_addr] = dm_wdata;
            wr_q.push_back({dm_addr, dm_wdata, dm_be});
          end else begin
            rd_addr = dm_addr;
            rd_cnt = rv_delay;
          end
        end
      end
    end
  end

  task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] opb,
                        input logic [31:0] exp_res, input logic exp_mis, input bit exp_wr,
                        input logic [31:0] exp_wdata, input bit exp_access,
                        input int exp_stall, input int exp_done_cyc, input string name);
    exp_t e;
    int ns = 0, nreq = 0, dc = -1;
    e.res = exp_res; e.mis = exp_mis;
    exp_q.push_back(e);
    if (exp_wr) exp_wr_q.push_back({addr[31:2], 2'b00, exp_wdata, 4'hF});
    @(negedge clk);
    mem_atomic_op = op; mem_addr = addr; mem_opB = opb; mem_is_atomic = 1'b1;
    for (int c = 0; c < 60; c++) begin
      #2;
      if (stall) ns++;
      if (dm_req) nreq++;
      if (amo_done) begin dc = c; mem_is_atomic = 1'b0; break; end
      @(negedge clk);
    end
    vectors++;
    if (dc < 0) begin
      miscompares++;
      $display("FAIL %s timeout: amo_done not seen, required within 60 cycles", name);
      mem_is_atomic = 1'b0;
      exp_q.delete(); exp_wr_q.delete(); wr_q.delete();
      return;
    end
    e = exp_q.pop_front();
    vectors++;
    if (amo_result !== e.res || amo_misaligned !== e.mis) begin
      miscompares++;
      $display("FAIL %s result: got %h mis %b, required %h mis %b", name, amo_result, amo_misaligned, e.res, e.mis);
    end
    vectors++;
    if (wr_q.size() != exp_wr_q.size()) begin
      miscompares++;
      $display("FAIL %s write count: got %0d, required %0d", name, wr_q.size(), exp_wr_q.size());
    end else begin
      while (wr_q.size() > 0) begin
        logic [67:0] a, b;
        a = wr_q.pop_front(); b = exp_wr_q.pop_front();
        if (a !== b) begin
          miscompares++;
          $display("FAIL %s write: got addr %h data %h be %h, required addr %h data %h be %h",
                   name, a[67:36], a[35:4], a[3:0], b[67:36], b[35:4], b[3:0]);
        end
      end
    end
    wr_q.delete(); exp_wr_q.delete();
    if (!exp_access) begin
      vectors++;
      if (nreq != 0) begin
        miscompares++;
        $display("FAIL %s no_access: dm_req seen %0d cycles, required 0", name, nreq);
      end
    end
    if (exp_stall >= 0) begin
      vectors++;
      if (ns != exp_stall) begin
        miscompares++;
        $display("FAIL %s stall_cycles: got %0d, required %0d", name, ns, exp_stall);
      end
    end
    if (exp_done_cyc >= 0) begin
      vectors++;
      if (dc != exp_done_cyc) begin
        miscompares++;
        $display("FAIL %s done_cycle: got %0d, required %0d", name, dc, exp_done_cyc);
      end
    end
    @(posedge clk); #1;
    vectors++;
    if (amo_done !== 1'b0 || amo_misaligned !== 1'b0 || amo_result !== exp_res) begin
      miscompares++;
      $display("FAIL %s hold: done %b mis %b result %h, required 0 0 %h", name, amo_done, amo_misaligned, amo_result, exp_res);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    vectors++;
    if ({dm_req, dm_we, dm_addr, dm_wdata, dm_be, stall, amo_done, amo_result, amo_misaligned} !== '0) begin
      miscompares++;
      $display("FAIL %s: req %b we %b addr %h wdata %h be %h stall %b done %b result %h mis %b, required all 0",
               name, dm_req, dm_we, dm_addr, dm_wdata, dm_be, stall, amo_done, amo_result, amo_misaligned);
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    #12;
    check_idle_outputs("reset");
    @(negedge clk); nrst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_amo_add();
    mem[32'h100] = 32'd5;
    run_op(4'd3, 32'h100, 32'd7, 32'd5, 1'b0, 1'b1, 32'd12, 1'b1, 4, -1, "amoadd");
  endtask

  task automatic test_lr_sc();
    mem[32'h200] = 32'hAA;
    run_op(4'd0, 32'h200, 32'd0, 32'hAA, 1'b0, 1'b0, 32'd0, 1'b1, -1, -1, "lr");
    run_op(4'd1, 32'h200, 32'h55, 32'd0, 1'b0, 1'b1, 32'h55, 1'b1, -1, -1, "sc_ok");
    run_op(4'd1, 32'h200, 32'h77, 32'd1, 1'b0, 1'b0, 32'd0, 1'b0, -1, -1, "sc_noresv");
  endtask

  task automatic test_snoop();
    run_op(4'd0, 32'h200, 32'd0, 32'h55, 1'b0, 1'b0, 32'd0, 1'b1, -1, -1, "lr_snoop");
    @(negedge clk); snoop_wr = 1'b1; snoop_addr = 32'h202;
    @(negedge clk); snoop_wr = 1'b0;
    run_op(4'd1, 32'h200, 32'h99, 32'd1, 1'b0, 1'b0, 32'd0, 1'b0, -1, -1, "sc_after_snoop");
  endtask

  task automatic test_minmax();
    mem[32'h300] = 32'hFFFF_FFFF;
    run_op(4'd7, 32'h300, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, -1, -1, "amomin");
    run_op(4'd9, 32'h300, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'd1, 1'b1, -1, -1, "amominu");
  endtask

  task automatic test_misaligned();
    run_op(4'd2, 32'h103, 32'd9, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 1, 1, "misaligned");
  endtask

  task automatic test_back_to_back();
    mem[32'h400] = 32'h0F0F_0000;
    run_op(4'd4, 32'h400, 32'h00FF_00FF, 32'h0F0F_0000, 1'b0, 1'b1, 32'h0FF0_00FF, 1'b1, 4, -1, "b2b_xor");
    run_op(4'd8, 32'h400, 32'h8000_0000, 32'h0FF0_00FF, 1'b0, 1'b1, 32'h0FF0_00FF, 1'b1, 4, -1, "b2b_max_tie_old");
    run_op(4'd10, 32'h400, 32'h8000_0000, 32'h0FF0_00FF, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 4, -1, "b2b_maxu");
    run_op(4'd12, 32'h400, 32'd3, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1, 1, "bad_op");
  endtask

  task automatic test_reset_mid();
    int bad_stall = 0, seen_req = 0;
    bit in_wait = 1'b0;
    mem[32'h500] = 32'h1234;
    gnt_hold = 3; rv_delay = 100;
    @(negedge clk);
    mem_atomic_op = 4'd2; mem_addr = 32'h500; mem_opB = 32'hDEAD; mem_is_atomic = 1'b1;
    for (int c = 0; c < 30 && !in_wait; c++) begin
      #2;
      if (!stall) bad_stall++;
      if (dm_req) seen_req++;
      else if (seen_req > 0) in_wait = 1'b1;
      if (!in_wait) @(negedge clk);
    end
    vectors++;
    if (!in_wait || seen_req != 4 || bad_stall != 0) begin
      miscompares++;
      $display("FAIL reset_mid wait: reached %b req_cycles %0d unstalled %0d, required 1 4 0", in_wait, seen_req, bad_stall);
    end
    repeat (2) begin
      @(negedge clk); #2;
      vectors++;
      if (stall !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_mid stall_in_wait: got %b, required 1", stall);
      end
    end
    mem_is_atomic = 1'b0;
    nrst = 1'b0;
    #1;
    check_idle_outputs("reset_mid outputs");
    @(negedge clk); @(negedge clk);
    nrst = 1'b1; rv_delay = 1;
    seen_req = 0;
    repeat (4) begin @(negedge clk); #2; if (dm_req || stall) seen_req++; end
    vectors++;
    if (seen_req != 0 || wr_q.size() != 0) begin
      miscompares++;
      $display("FAIL reset_mid after: busy cycles %0d writes %0d, required 0 0", seen_req, wr_q.size());
    end
    wr_q.delete();
    run_op(4'd3, 32'h300, 32'd2, 32'd1, 1'b0, 1'b1, 32'd3, 1'b1, 4, -1, "post_reset_add");
  endtask

  initial begin
    test_reset();
    test_amo_add();
    test_lr_sc();
    test_snoop();
    test_minmax();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
